// File: rtl/muldiv_seq.sv
// Sequential 32x32 multiply / restoring divide that borrows a shared external ALU.
// Define MULDIV_SIGNED_EN to add the signed MULT/DIV ops (op 10/11).
module muldiv_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [31:0] alu_res,
    output logic [3:0]  alu_ctr,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    logic [1:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] opnd_q, opnd_d;
    logic        dbz_q, dbz_d;
    logic        op_en;
    logic [31:0] a_mag, b_mag;
    logic        carry;
    logic [31:0] step_hi, step_lo;
    logic [31:0] rem_sh;
    logic        qbit;
`ifdef MULDIV_SIGNED_EN
    logic        neg_q, neg_d;
    logic        neg_rem_q, neg_rem_d;
    logic [63:0] prod_neg;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opnd_d  = opnd_q;
        dbz_d   = dbz_q;
        alu_ctr = ALU_ADD;
        alu_in1 = '0;
        alu_in2 = '0;
        carry   = 1'b0;
        step_hi = hi_q;
        step_lo = lo_q;
        rem_sh  = {hi_q[30:0], lo_q[31]};
        qbit    = 1'b0;
`ifdef MULDIV_SIGNED_EN
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        prod_neg  = '0;
        op_en     = 1'b1;
        a_mag     = (op[1] && rs_val[31]) ? (~rs_val + 32'd1) : rs_val;
        b_mag     = (op[1] && rt_val[31]) ? (~rt_val + 32'd1) : rt_val;
`else
        op_en     = ~op[1];
        a_mag     = rs_val;
        b_mag     = rt_val;
`endif

        case (state_q)
            IDLE: begin
                if (start && op_en) begin
                    cnt_d = '0;
                    dbz_d = 1'b0;
                    hi_d  = '0;
`ifdef MULDIV_SIGNED_EN
                    neg_d     = op[1] & (rs_val[31] ^ rt_val[31]);
                    neg_rem_d = op[1] & rs_val[31];
`endif
                    if (op[0]) begin
                        opnd_d  = b_mag;
                        lo_d    = a_mag;
                        state_d = DIV;
                    end else begin
                        opnd_d  = a_mag;
                        lo_d    = b_mag;
                        state_d = MUL;
                    end
                end
            end

            MUL: begin
                alu_ctr = ALU_ADD;
                alu_in1 = hi_q;
                alu_in2 = opnd_q;
                // The ALU add drops bit 32; it is recovered from unsigned wrap-around.
                if (lo_q[0]) begin
                    carry   = (alu_res < hi_q);
                    step_hi = {carry, alu_res[31:1]};
                    step_lo = {alu_res[0], lo_q[31:1]};
                end else begin
                    step_hi = {1'b0, hi_q[31:1]};
                    step_lo = {hi_q[0], lo_q[31:1]};
                end
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d = DONE;
`ifdef MULDIV_SIGNED_EN
                    prod_neg = ~{step_hi, step_lo} + 64'd1;
                    if (neg_q) begin
                        hi_d = prod_neg[63:32];
                        lo_d = prod_neg[31:0];
                    end
`endif
                end
            end

            DIV: begin
                if (opnd_q == '0) begin
                    // lo_q still holds the untouched dividend (magnitude).
                    hi_d    = lo_q;
                    lo_d    = '1;
                    dbz_d   = 1'b1;
                    state_d = DONE;
`ifdef MULDIV_SIGNED_EN
                    if (neg_rem_q) begin
                        hi_d = ~lo_q + 32'd1;
                    end
`endif
                end else begin
                    alu_ctr = ALU_SUB;
                    alu_in1 = rem_sh;
                    alu_in2 = opnd_q;
                    if ({hi_q, lo_q[31]} >= {1'b0, opnd_q}) begin
                        step_hi = alu_res;
                        qbit    = 1'b1;
                    end else begin
                        step_hi = rem_sh;
                        qbit    = 1'b0;
                    end
                    step_lo = {lo_q[30:0], qbit};
                    hi_d    = step_hi;
                    lo_d    = step_lo;
                    cnt_d   = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_d = DONE;
`ifdef MULDIV_SIGNED_EN
                        if (neg_q) begin
                            lo_d = ~step_lo + 32'd1;
                        end
                        if (neg_rem_q) begin
                            hi_d = ~step_hi + 32'd1;
                        end
`endif
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            opnd_q  <= '0;
            dbz_q   <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opnd_q  <= opnd_d;
            dbz_q   <= dbz_d;
`ifdef MULDIV_SIGNED_EN
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
`endif
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed cases plus random ops against an arithmetic model.
// Honours MULDIV_SIGNED_EN the same way as the design.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic [31:0] alu_res;
    logic [3:0]  alu_ctr;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int failures = 0;

    muldiv_seq dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .alu_res     (alu_res),
        .alu_ctr     (alu_ctr),
        .alu_in1     (alu_in1),
        .alu_in2     (alu_in2),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    // Shared ALU as seen by the block: combinational add/sub.
    assign alu_res = (alu_ctr == 4'b0110) ? (alu_in1 - alu_in2) : (alu_in1 + alu_in2);

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] mh, output logic [31:0] ml, output logic mz);
        logic [63:0] u;
        longint      p;
        longint      q;
        longint      r;
        mz = 1'b0;
        if (o[0] && b == 32'd0) begin
            mh = a;
            ml = '1;
            mz = 1'b1;
        end else begin
            case (o)
                2'b00: begin
                    u  = {32'd0, a} * {32'd0, b};
                    mh = u[63:32];
                    ml = u[31:0];
                end
                2'b01: begin
                    ml = a / b;
                    mh = a % b;
                end
                2'b10: begin
                    p  = longint'($signed(a)) * longint'($signed(b));
                    mh = p[63:32];
                    ml = p[31:0];
                end
                default: begin
                    q  = longint'($signed(a)) / longint'($signed(b));
                    r  = longint'($signed(a)) % longint'($signed(b));
                    mh = r[31:0];
                    ml = q[31:0];
                end
            endcase
        end
    endfunction

    // Issue one op, optionally poke a stray start at iteration 10, and check timing and results.
    task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input string tag, input bit intrude);
        logic [31:0] eh;
        logic [31:0] el;
        logic        ez;
        int          k;
        int          busy_n;
        int          extra;
        int          lat;
        logic [3:0]  mid_ctr;
        logic [31:0] mid_in2;
        model(o, a, b, eh, el, ez);
        lat = ez ? 1 : 32;
        @(negedge clk);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(negedge clk);
        start = 1'b0;
        rs_val = $urandom; rt_val = $urandom;
        k = 0; busy_n = 0;
        mid_ctr = 4'hx; mid_in2 = 'x;
        while (!done && k < 60) begin
            if (busy) busy_n++;
            if (k == 5) begin
                mid_ctr = alu_ctr;
                mid_in2 = alu_in2;
            end
            if (intrude && k == 10) begin
                start = 1'b1; op = 2'b00; rs_val = 32'd3; rt_val = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        check({tag, ".latency"}, 64'(k), 64'(lat));
        check({tag, ".busy_cycles"}, 64'(busy_n), 64'(lat));
        check({tag, ".busy_at_done"}, 64'(busy), 64'd1);
        check({tag, ".hi"}, 64'(hi), 64'(eh));
        check({tag, ".lo"}, 64'(lo), 64'(el));
        check({tag, ".dbz"}, 64'(div_by_zero), 64'(ez));
        check({tag, ".alu_idle"}, {28'd0, alu_ctr, alu_in1}, {28'd0, 4'b0010, 32'd0});
        if (!ez) begin
            check({tag, ".mid_ctr"}, 64'(mid_ctr), o[0] ? 64'h6 : 64'h2);
            if (!o[1]) check({tag, ".mid_in2"}, 64'(mid_in2), o[0] ? 64'(b) : 64'(a));
        end
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        check({tag, ".quiet_after"}, 64'(extra), 64'd0);
        check({tag, ".hold"}, {hi, lo}, {eh, el});
    endtask

    logic [31:0] rh;
    logic [31:0] rl;
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    int          quiet;

    initial begin
        // Reset state while reset is held low.
        #12;
        check("reset.busy", 64'(busy), 64'd0);
        check("reset.done", 64'(done), 64'd0);
        check("reset.dbz", 64'(div_by_zero), 64'd0);
        check("reset.hilo", {hi, lo}, 64'd0);
        check("reset.alu", {28'd0, alu_ctr, alu_in1}, {28'd0, 4'b0010, 32'd0});
        check("reset.alu_in2", 64'(alu_in2), 64'd0);
        @(posedge clk); #2 reset = 1'b1;

        run(2'b00, 32'd7, 32'd6, "multu_7x6", 1'b0);
        run(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max", 1'b0);
        run(2'b01, 32'd100, 32'd7, "divu_100_7", 1'b0);
        run(2'b01, 32'd5, 32'd0, "divu_by_zero", 1'b0);
        run(2'b01, 32'd12345678, 32'd1000, "divu_intrude", 1'b1);
        run(2'b01, 32'hFFFFFFFF, 32'h80000000, "divu_big", 1'b0);

        // Abort a multiply mid-flight with an asynchronous reset.
        @(negedge clk);
        start = 1'b1; op = 2'b00; rs_val = 32'd12345; rt_val = 32'd6789;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort.busy", 64'(busy), 64'd0);
        check("abort.done", 64'(done), 64'd0);
        check("abort.hilo", {hi, lo}, 64'd0);
        check("abort.alu", {alu_ctr, alu_in1, alu_in2}, {4'b0010, 32'd0, 32'd0});
        @(posedge clk); #2 reset = 1'b1;
        run(2'b00, 32'd2, 32'd3, "after_abort", 1'b0);

`ifdef MULDIV_SIGNED_EN
        run(2'b10, 32'hFFFFFFFD, 32'd5, "mult_neg3x5", 1'b0);
        run(2'b11, 32'hFFFFFFF9, 32'd2, "div_neg7_2", 1'b0);
        run(2'b11, 32'hFFFFFFF9, 32'd0, "div_neg_by_zero", 1'b0);
        run(2'b11, 32'h80000000, 32'hFFFFFFFF, "div_minint", 1'b0);
`else
        // Signed op must be ignored when the feature is not built in.
        model(2'b01, 32'hFFFFFFFF, 32'h80000000, rh, rl, quiet[0]);
        @(negedge clk);
        start = 1'b1; op = 2'b10; rs_val = 32'hFFFFFFFD; rt_val = 32'd5;
        @(negedge clk);
        start = 1'b0;
        quiet = 0;
        for (int i = 0; i < 6; i++) begin
            if (busy || done) quiet++;
            @(negedge clk);
        end
        check("signed_off.quiet", 64'(quiet), 64'd0);
        check("signed_off.hold", {hi, lo}, 64'd6);
`endif

        for (int n = 0; n < 24; n++) begin
`ifdef MULDIV_SIGNED_EN
            ro = 2'($urandom_range(0, 3));
`else
            ro = 2'($urandom_range(0, 1));
`endif
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) rb = '0;
            run(ro, ra, rb, $sformatf("rand%0d_op%0d", n, ro), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The block SHALL have one clock, clk; all state SHALL update on its rising edge.
REQ-002 The block SHALL use reset, which SHALL be asynchronous and active-low.
REQ-003 Port list (name, direction, width, meaning):
- clk  in  1  clock.
- reset  in  1  async active-low reset.
- start  in  1  request; sampled only in IDLE.
- op  in  2  00 MULTU, 01 DIVU, 10 MULT, 11 DIV.
- rs_val  in  32  multiplicand / dividend.
- rt_val  in  32  multiplier / divisor.
- alu_res  in  32  result returned by the shared 32-bit ALU, same cycle.
- alu_ctr  out  4  ALU operation: 0010 add, 0110 sub.
- alu_in1  out  32  ALU operand 1.
- alu_in2  out  32  ALU operand 2.
- busy  out  1  operation in progress; pipeline stall.
- done  out  1  one-cycle pulse; hi/lo valid.
- div_by_zero  out  1  set with done when a divide had rt_val==0.
- hi  out  32  HI result: product[63:32] or remainder.
- lo  out  32  LO result: product[31:0] or quotient.

Function
REQ-004 The block SHALL have the states IDLE, MUL, DIV and DONE.
REQ-005 In IDLE with start=1 and an enabled op, the block SHALL latch its operands, clear the 6-bit iteration counter, and move to MUL (op x0) or DIV (op x1).
REQ-006 In MUL, each cycle SHALL drive alu_ctr=0010, alu_in1=HI and alu_in2=multiplicand; if LO[0]=1, {carry,HI,LO} SHALL be set to {carry,alu_res,LO}>>1, with carry=(alu_res<HI) unsigned; otherwise {0,HI,LO} SHALL be shifted right by 1.
REQ-007 In DIV, each cycle SHALL drive alu_ctr=0110, alu_in1={rem[30:0],LO[31]} and alu_in2=divisor; if {rem,LO[31]}>=divisor (33-bit unsigned), rem SHALL take alu_res and the shifted-in quotient bit SHALL be 1; otherwise rem SHALL take the shifted value and the quotient bit SHALL be 0 (restoring division).
REQ-008 After exactly 32 iterations (counter 0..31), MUL/DIV SHALL move to DONE, and DONE SHALL always move to IDLE.
REQ-009 Timing SHALL be: start accepted at edge N; busy high from N to N+33; done high for exactly the one cycle between N+32 and N+33.
REQ-010 A divide with rt_val==0 SHALL skip iterations and go IDLE->DONE at edge N+1, setting hi=rs_val, lo=32'hFFFFFFFF and div_by_zero=1.
REQ-011 start while busy SHALL be ignored; operands SHALL be captured only at acceptance.
REQ-012 hi/lo SHALL hold their last result until the next accepted start; div_by_zero SHALL clear on the next acceptance.
REQ-013 In IDLE and DONE, the block SHALL drive alu_ctr=0010 and alu_in1=alu_in2=0.
REQ-014 An op that is not enabled SHALL be ignored in IDLE: no state change and no done.

Reset
REQ-015 When reset=0, the block SHALL immediately go to IDLE (including mid-operation, aborting it), clear the counter and all internal registers, and set busy=0, done=0, div_by_zero=0, hi=0, lo=0, alu_ctr=0010, alu_in1=0 and alu_in2=0.
REQ-016 After reset deasserts, the first start SHALL be accepted on the first rising edge.

Configuration
REQ-017 With MULDIV_SIGNED_EN defined, ops 10/11 SHALL be supported: operand magnitudes SHALL be taken at acceptance; the product/quotient SHALL be negated when the operand signs differ; the remainder SHALL take the dividend's sign; latency SHALL be identical to the unsigned ops.
REQ-018 Without MULDIV_SIGNED_EN, ops 10/11 SHALL be ignored per REQ-014, and no sign logic SHALL be present.

Verification
REQ-019 MULTU rs=7, rt=6 -> done at edge N+32 with hi=0, lo=42, busy high for 33 cycles.
REQ-020 MULTU rs=rt=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001 (exercises the carry path).
REQ-021 DIVU rs=100, rt=7 -> lo=14, hi=2, div_by_zero=0; DIVU rs=5, rt=0 -> done at N+1, lo=32'hFFFFFFFF, hi=5, div_by_zero=1.
REQ-022 start with op=00, rs=3, rt=3 pulsed at iteration 10 of a running DIVU -> ignored; the DIVU result is correct and exactly one done pulse occurs.
REQ-023 reset=0 at iteration 10 of a MULTU -> busy=0, hi=lo=0 with no clock edge; a new MULTU 2*3 afterwards -> lo=6.
REQ-024 With MULDIV_SIGNED_EN: MULT -3*5 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFF1; DIV -7/2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. Without the macro: op=10 -> busy stays 0.
